trace_emitter: RTL and testbench

Hardware trace port for the diad pipeline. It captures one record per instruction retiring from the RO stage (PC, instruction word, result), buffers the records in a small FIFO, and emits them as framed bytes on a valid/ready byte stream. External benches and host-side capture logic read this stream instead of probing pipeline internals.

---
 rtl/trace_emitter.sv | 163 ++++++++++++++++
 tb/tb_trace_emitter.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/trace_emitter.sv
// ============================================================================
// trace_emitter: captures retired records into a FIFO and emits framed bytes.
// Option macro: TRACE_RESULT_EN (adds the result field). Rev 1.0
// ============================================================================
`default_nettype none

module trace_emitter #(
  parameter int PC_WIDTH    = 24,
  parameter int INSTR_WIDTH = 24,
  parameter int DATA_WIDTH  = 24,
  parameter int DEPTH       = 4
) (
  input  logic                   iw_clk,
  input  logic                   iw_rst,
  input  logic                   iw_enable,
  input  logic                   iw_valid,
  input  logic [PC_WIDTH-1:0]    iw_pc,
  input  logic [INSTR_WIDTH-1:0] iw_instr,
  input  logic [DATA_WIDTH-1:0]  iw_result,
  output logic                   ow_tx_valid,
  output logic [7:0]             ow_tx_data,
  output logic                   ow_tx_last,
  input  logic                   iw_tx_ready,
  output logic [7:0]             ow_dropped,
  output logic [7:0]             ow_seq
);

  localparam int PC_B  = (PC_WIDTH + 7) / 8;
  localparam int IN_B  = (INSTR_WIDTH + 7) / 8;
`ifdef TRACE_RESULT_EN
  localparam int RES_B = (DATA_WIDTH + 7) / 8;
`else
  localparam int RES_B = 0;
`endif
  localparam int REC_B   = 1 + PC_B + IN_B + RES_B;
  localparam int REC_W   = REC_B * 8;
  localparam int FRAME_B = REC_B + 1;
  localparam int IDX_W   = $clog2(FRAME_B);
  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam logic [7:0]       SYNC     = 8'hD1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_B - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  typedef enum logic [0:0] {IDLE = 1'b0, SEND = 1'b1} state_t;

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [7:0]           data_q, data_d;
  logic                 last_q, last_d;
  logic [7:0]           seq_q, dropped_q;
  logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]     count_q;
  logic [REC_W-1:0]     mem_q [DEPTH];

  logic                 attempt, pop, push;
  logic [REC_W-1:0]     rec, head;
  logic [IDX_W-1:0]     next_idx;
  logic [7:0]           next_byte;

  // Record layout, MSB first: seq | pc | instr | result, each byte-padded.
  always_comb begin
    rec = '0;
    rec[REC_W-1 -: 8] = seq_q;
    rec[(IN_B + RES_B) * 8 +: PC_WIDTH] = iw_pc;
    rec[RES_B * 8 +: INSTR_WIDTH] = iw_instr;
`ifdef TRACE_RESULT_EN
    rec[0 +: DATA_WIDTH] = iw_result;
`endif
  end

`ifndef TRACE_RESULT_EN
  logic unused_result;
  assign unused_result = ^iw_result;
`endif

  assign attempt   = iw_valid & iw_enable;
  assign pop       = (state_q == SEND) & iw_tx_ready & last_q;
  assign push      = attempt & ((count_q != FULL_CNT) | pop);
  assign head      = mem_q[rd_ptr_q];
  assign next_idx  = idx_q + 1'b1;
  assign next_byte = 8'(head >> (8 * (REC_B - int'(next_idx))));

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    data_d  = data_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          state_d = SEND;
          idx_d   = '0;
          data_d  = SYNC;
          last_d  = 1'b0;
        end
      end
      SEND: begin
        if (iw_tx_ready) begin
          if (last_q) begin
            idx_d  = '0;
            last_d = 1'b0;
            // A record pushed this same cycle also counts as remaining.
            if (count_q > CNT_W'(1) || push) begin
              data_d = SYNC;
            end else begin
              state_d = IDLE;
              data_d  = '0;
            end
          end else begin
            idx_d  = next_idx;
            data_d = next_byte;
            last_d = (next_idx == LAST_IDX);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge iw_clk or posedge iw_rst) begin
    if (iw_rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      data_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      last_q  <= last_d;
    end
  end

  always_ff @(posedge iw_clk or posedge iw_rst) begin
    if (iw_rst) begin
      seq_q     <= '0;
      dropped_q <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
    end else begin
      if (attempt) seq_q <= seq_q + 8'd1;
      if (attempt && !push && dropped_q != 8'hFF) dropped_q <= dropped_q + 8'd1;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge iw_clk) begin
    if (push) mem_q[wr_ptr_q] <= rec;
  end

  assign ow_tx_valid = (state_q == SEND);
  assign ow_tx_data  = data_q;
  assign ow_tx_last  = last_q;
  assign ow_dropped  = dropped_q;
  assign ow_seq      = seq_q;

endmodule

`default_nettype wire

// File: tb/tb_trace_emitter.sv
// Directed bench for trace_emitter; frame length follows TRACE_RESULT_EN.
`default_nettype none

module tb_trace_emitter;
`ifdef TRACE_RESULT_EN
  localparam int FB = 11;
`else
  localparam int FB = 8;
`endif

  logic        clk = 1'b0, rst = 1'b1, en = 1'b0, vld = 1'b0, rdy = 1'b0;
  logic [23:0] pc = '0, ins = '0, res = '0;
  logic        tx_valid, tx_last;
  logic [7:0]  tx_data, dropped, seq;
  logic [7:0]  exp_b [0:10];
  int          total = 0, passed = 0, fails = 0;

  trace_emitter dut (
    .iw_clk(clk), .iw_rst(rst), .iw_enable(en), .iw_valid(vld),
    .iw_pc(pc), .iw_instr(ins), .iw_result(res),
    .ow_tx_valid(tx_valid), .ow_tx_data(tx_data), .ow_tx_last(tx_last),
    .iw_tx_ready(rdy), .ow_dropped(dropped), .ow_seq(seq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Walks one frame from the current sample point; every cycle must be valid.
  task automatic expect_frame(input logic [7:0] s, input bit toggle, input bit push_last);
    int  k   = 0;
    int  cyc = 0;
    bit  r;
    while (k < FB && cyc < 4 * FB + 8) begin
      r   = toggle ? (cyc[0] == 1'b0) : 1'b1;
      rdy = r;
      chk("frame_valid", tx_valid, 1);
      chk("frame_byte", tx_data, (k == 1) ? s : exp_b[k]);
      chk("frame_last", tx_last, k == FB - 1);
      if (push_last && r && k == FB - 1) vld = 1'b1;
      tick();
      vld = 1'b0;
      if (r) k++;
      cyc++;
    end
    if (k != FB) chk("frame_timeout", k, FB);
  endtask

  initial begin
    exp_b = '{8'hD1, 8'h00, 8'h00, 8'h00, 8'h10, 8'h12, 8'h34, 8'h56,
              8'hAB, 8'hCD, 8'hEF};
    pc  = 24'h000010;
    ins = 24'h123456;
    res = 24'hABCDEF;
    en  = 1'b1;
    repeat (2) tick();
    chk("rst_valid", tx_valid, 0);
    chk("rst_data", tx_data, 0);
    chk("rst_last", tx_last, 0);
    chk("rst_dropped", dropped, 0);
    chk("rst_seq", seq, 0);
    rst = 1'b0;
    rdy = 1'b1;

    // Single record with ready held high
    vld = 1'b1; tick(); vld = 1'b0;
    chk("single_seq", seq, 1);
    chk("single_latency_idle", tx_valid, 0);
    tick();
    expect_frame(8'h00, 1'b0, 1'b0);
    chk("single_idle_after", tx_valid, 0);

    // Same record under alternating backpressure
    vld = 1'b1; tick(); vld = 1'b0;
    tick();
    expect_frame(8'h01, 1'b1, 1'b0);
    chk("bp_idle_after", tx_valid, 0);
    chk("bp_seq", seq, 2);

    // Overflow from a fresh reset
    rst = 1'b1; tick(); rst = 1'b0;
    rdy = 1'b0;
    vld = 1'b1; repeat (6) tick(); vld = 1'b0;
    chk("ovf_dropped", dropped, 2);
    chk("ovf_seq", seq, 6);
    rdy = 1'b1;
    expect_frame(8'h00, 1'b0, 1'b0);
    expect_frame(8'h01, 1'b0, 1'b0);
    expect_frame(8'h02, 1'b0, 1'b0);
    expect_frame(8'h03, 1'b0, 1'b0);
    chk("ovf_idle_after", tx_valid, 0);

    // Full FIFO, capture on the last-byte handshake of the head frame
    rdy = 1'b0;
    vld = 1'b1; repeat (4) tick(); vld = 1'b0;
    chk("full_seq", seq, 10);
    chk("full_dropped", dropped, 2);
    rdy = 1'b1;
    expect_frame(8'h06, 1'b0, 1'b1);
    chk("pp_dropped", dropped, 2);
    chk("pp_seq", seq, 11);
    expect_frame(8'h07, 1'b0, 1'b0);
    expect_frame(8'h08, 1'b0, 1'b0);
    expect_frame(8'h09, 1'b0, 1'b0);
    expect_frame(8'h0A, 1'b0, 1'b0);
    chk("pp_idle_after", tx_valid, 0);

    // Reset in the middle of a frame
    vld = 1'b1; tick(); vld = 1'b0;
    tick();
    repeat (5) tick();
    chk("mid_byte5", tx_data, exp_b[5]);
    chk("mid_valid", tx_valid, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_valid", tx_valid, 0);
    chk("async_rst_data", tx_data, 0);
    chk("async_rst_dropped", dropped, 0);
    chk("async_rst_seq", seq, 0);
    tick();
    rst = 1'b0;
    vld = 1'b1; tick(); vld = 1'b0;
    tick();
    expect_frame(8'h00, 1'b0, 1'b0);
    chk("post_rst_seq", seq, 1);
    chk("post_rst_idle", tx_valid, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
